// File: rtl/i2s_rx.sv
// Philips-format I2S receiver: oversamples an asynchronous sck/ws/sd bus on clk
// and delivers one left/right sample pair per frame with a single-cycle valid strobe.
module i2s_rx #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  sd,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  valid,
    output logic                  word_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [0:0] ST_HUNT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);

    logic [1:0]            sck_sync_q, ws_sync_q, sd_sync_q;
    logic                  sck_dly_q;
    logic [0:0]            state_q, state_d;
    logic                  ws_prev_q, ws_prev_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [DATA_WIDTH-1:0] left_hold_q, left_hold_d;
    logic                  left_short_q, left_short_d;
    logic [DATA_WIDTH-1:0] left_q, left_d;
    logic [DATA_WIDTH-1:0] right_q, right_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  sck_rise, ws_s, sd_s;
    logic [DATA_WIDTH-1:0] bit_mask, word_upd, word_fin;
    logic [CW-1:0]         cnt_upd;
    logic                  word_short;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sck_sync_q <= '0;
            ws_sync_q  <= '0;
            sd_sync_q  <= '0;
            sck_dly_q  <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck};
            ws_sync_q  <= {ws_sync_q[0], ws};
            sd_sync_q  <= {sd_sync_q[0], sd};
            sck_dly_q  <= sck_sync_q[1];
        end
    end

    assign sck_rise = sck_sync_q[1] & ~sck_dly_q;
    assign ws_s     = ws_sync_q[1];
    assign sd_s     = sd_sync_q[1];

    // The one-hot mask shifts out to zero once the count saturates, so extra bits drop naturally.
    assign bit_mask   = MSB_ONE >> bit_cnt_q;
    assign word_upd   = sd_s ? (word_q | bit_mask) : word_q;
    assign cnt_upd    = (bit_cnt_q < CNT_FULL) ? bit_cnt_q + CW'(1) : bit_cnt_q;
    assign word_fin   = (bit_cnt_q == '0) ? '0 : word_upd;
    assign word_short = (cnt_upd < CNT_FULL);

    always_comb begin
        state_d      = state_q;
        ws_prev_d    = ws_prev_q;
        bit_cnt_d    = bit_cnt_q;
        word_d       = word_q;
        left_hold_d  = left_hold_q;
        left_short_d = left_short_q;
        left_d       = left_q;
        right_d      = right_q;
        valid_d      = 1'b0;
        err_d        = err_q;
        if (sck_rise) begin
            ws_prev_d = ws_s;
            if (state_q == ST_HUNT) begin
                if (ws_prev_q && !ws_s) begin
                    state_d   = ST_RUN;
                    bit_cnt_d = '0;
                    word_d    = '0;
                end
            end else if (ws_s != ws_prev_q) begin
                if (!ws_s) begin
                    left_d  = left_hold_q;
                    right_d = word_fin;
                    valid_d = 1'b1;
                    err_d   = left_short_q | word_short;
                end else begin
                    left_hold_d  = word_fin;
                    left_short_d = word_short;
                end
                word_d    = '0;
                bit_cnt_d = '0;
            end else begin
                word_d    = word_upd;
                bit_cnt_d = cnt_upd;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_HUNT;
            ws_prev_q    <= 1'b0;
            bit_cnt_q    <= '0;
            word_q       <= '0;
            left_hold_q  <= '0;
            left_short_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            ws_prev_q    <= ws_prev_d;
            bit_cnt_q    <= bit_cnt_d;
            word_q       <= word_d;
            left_hold_q  <= left_hold_d;
            left_short_q <= left_short_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
        end
    end

    assign left_data  = left_q;
    assign right_data = right_q;
    assign valid      = valid_q;
    assign word_err   = err_q;

endmodule

// File: tb/tb_i2s_rx.sv
// Self-checking bench for i2s_rx: drives I2S frames at clk/8 and checks every
// valid pulse against a frame-level model of the expected samples and timing.
module tb_i2s_rx;

    localparam int DW   = 16;
    localparam int HALF = 40;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sck = 1'b0;
    logic ws = 1'b0;
    logic sd = 1'b0;
    logic [DW-1:0] left_data, right_data;
    logic valid, word_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lsbCyc = 0;

    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          e;
        int            c;
    } pulse_t;
    pulse_t pulses[$];

    i2s_rx #(.DATA_WIDTH(DW)) dut (
        .clk(clk),
        .reset(reset),
        .sck(sck),
        .ws(ws),
        .sd(sd),
        .left_data(left_data),
        .right_data(right_data),
        .valid(valid),
        .word_err(word_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every cycle with valid high is logged, so a stretched pulse shows up as an extra entry.
    always @(negedge clk) begin
        if (valid === 1'b1) pulses.push_back('{left_data, right_data, word_err, cyc});
    end

    // Expected sample: the slot's bits MSB-justified, keeping the first DW bits, zero-filled.
    function automatic logic [DW-1:0] expectWord(input logic [31:0] data, input int n);
        logic [63:0] full;
        full = 64'(data) << (64 - n);
        return full[63 -: DW];
    endfunction

    task automatic sendBit(input logic w, input logic d, input logic markLsb);
        ws = w;
        sd = d;
        #HALF;
        sck = 1'b1;
        if (markLsb) lsbCyc = cyc;
        #HALF;
        sck = 1'b0;
    endtask

    // ws flips one bit early, so the slot's LSB goes out with the next channel's ws.
    task automatic sendWord(input logic w, input logic [31:0] data, input int n, input logic markLsb);
        for (int i = n - 1; i >= 1; i--) sendBit(w, data[i], 1'b0);
        sendBit(~w, data[0], markLsb);
    endtask

    task automatic sendFrame(input int ln, input logic [31:0] ld, input int rn, input logic [31:0] rd);
        sendWord(1'b0, ld, ln, 1'b0);
        sendWord(1'b1, rd, rn, 1'b1);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            sck = 1'($urandom);
            ws  = 1'($urandom);
            sd  = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({left_data, right_data, valid, word_err} !== '0) begin
                errors++;
                $display("[TB] FAIL reset_outputs: got l=%h r=%h v=%b e=%b expected all 0",
                         left_data, right_data, valid, word_err);
            end
        end
        sck = 1'b0;
        ws  = 1'b0;
        sd  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_startup;
        logic [31:0] ld, rd;
        pulse_t p;
        sendWord(1'b0, $urandom, 5, 1'b0);
        sendWord(1'b1, $urandom, 16, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (pulses.size() != 0) begin
            errors++;
            $display("[TB] FAIL startup_early_valid: got %0d pulses expected 0", pulses.size());
        end
        pulses.delete();
        ld = $urandom & 32'hFFFF;
        rd = $urandom & 32'hFFFF;
        sendFrame(16, ld, 16, rd);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("[TB] FAIL startup_count: got %0d pulses expected 1", pulses.size());
        end
        if (pulses.size() > 0) begin
            p = pulses[0];
            checks++;
            if ({p.l, p.r, p.e} !== {ld[15:0], rd[15:0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL startup_data: got %h/%h/%b expected %h/%h/0",
                         p.l, p.r, p.e, ld[15:0], rd[15:0]);
            end
        end
        pulses.delete();
    endtask

    task automatic test_basic;
        pulse_t p;
        sendFrame(16, 32'hA5C3, 16, 32'h1234);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d pulses expected 1", pulses.size());
        end
        if (pulses.size() > 0) begin
            p = pulses[0];
            checks++;
            if (p.l !== 16'hA5C3) begin
                errors++;
                $display("[TB] FAIL basic_left: got %h expected a5c3", p.l);
            end
            checks++;
            if (p.r !== 16'h1234) begin
                errors++;
                $display("[TB] FAIL basic_right: got %h expected 1234", p.r);
            end
            checks++;
            if (p.e !== 1'b0) begin
                errors++;
                $display("[TB] FAIL basic_err: got %b expected 0", p.e);
            end
            checks++;
            if (p.c != lsbCyc + 3) begin
                errors++;
                $display("[TB] FAIL basic_latency: got cycle %0d expected %0d", p.c, lsbCyc + 3);
            end
        end
        pulses.delete();
    endtask

    task automatic test_mid_start;
        pulse_t p;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sendWord(1'b1, $urandom, 9, 1'b0);
        sendFrame(16, 32'h0001, 16, 32'h8000);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("[TB] FAIL midstart_count: got %0d pulses expected 1", pulses.size());
        end
        if (pulses.size() > 0) begin
            p = pulses[0];
            checks++;
            if ({p.l, p.r, p.e} !== {16'h0001, 16'h8000, 1'b0}) begin
                errors++;
                $display("[TB] FAIL midstart_data: got %h/%h/%b expected 0001/8000/0", p.l, p.r, p.e);
            end
        end
        pulses.delete();
    endtask

    task automatic test_wide_slots;
        pulse_t p;
        sendFrame(24, 32'hABCDEF, 24, 32'h123456);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("[TB] FAIL wide_count: got %0d pulses expected 1", pulses.size());
        end
        if (pulses.size() > 0) begin
            p = pulses[0];
            checks++;
            if ({p.l, p.r, p.e} !== {16'hABCD, 16'h1234, 1'b0}) begin
                errors++;
                $display("[TB] FAIL wide_data: got %h/%h/%b expected abcd/1234/0", p.l, p.r, p.e);
            end
        end
        pulses.delete();
    endtask

    task automatic test_short_word;
        pulse_t p;
        sendFrame(8, 32'hFF, 16, 32'h5555);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("[TB] FAIL short_count: got %0d pulses expected 1", pulses.size());
        end
        if (pulses.size() > 0) begin
            p = pulses[0];
            checks++;
            if ({p.l, p.r, p.e} !== {16'hFF00, 16'h5555, 1'b1}) begin
                errors++;
                $display("[TB] FAIL short_data: got %h/%h/%b expected ff00/5555/1", p.l, p.r, p.e);
            end
        end
        pulses.delete();
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] ld, rd;
        pulse_t p;
        sendWord(1'b0, 32'h1357, 16, 1'b0);
        for (int i = 15; i >= 8; i--) sendBit(1'b1, 1'($urandom), 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({left_data, right_data, valid, word_err} !== '0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got l=%h r=%h v=%b e=%b expected all 0",
                     left_data, right_data, valid, word_err);
        end
        reset = 1'b1;
        pulses.delete();
        sendFrame(16, $urandom, 16, $urandom);
        ld = $urandom & 32'hFFFF;
        rd = $urandom & 32'hFFFF;
        sendFrame(16, ld, 16, rd);
        checks++;
        if (pulses.size() != 1) begin
            errors++;
            $display("[TB] FAIL midreset_count: got %0d pulses expected 1", pulses.size());
        end
        if (pulses.size() > 0) begin
            p = pulses[0];
            checks++;
            if ({p.l, p.r, p.e} !== {ld[15:0], rd[15:0], 1'b0}) begin
                errors++;
                $display("[TB] FAIL midreset_data: got %h/%h/%b expected %h/%h/0",
                         p.l, p.r, p.e, ld[15:0], rd[15:0]);
            end
        end
        pulses.delete();
    endtask

    task automatic test_random_frames;
        int ln, rn;
        logic [31:0] ld, rd;
        logic [DW-1:0] expL, expR;
        logic expE;
        pulse_t p;
        for (int f = 0; f < 12; f++) begin
            ln = $urandom_range(32, 2);
            rn = $urandom_range(32, 2);
            ld = $urandom;
            rd = $urandom;
            expL = expectWord(ld, ln);
            expR = expectWord(rd, rn);
            expE = (ln < DW) || (rn < DW);
            sendFrame(ln, ld, rn, rd);
            checks++;
            if (pulses.size() != 1) begin
                errors++;
                $display("[TB] FAIL random_count[%0d]: got %0d pulses expected 1", f, pulses.size());
            end
            if (pulses.size() > 0) begin
                p = pulses[0];
                checks++;
                if ({p.l, p.r, p.e} !== {expL, expR, expE}) begin
                    errors++;
                    $display("[TB] FAIL random_data[%0d] (ln=%0d rn=%0d): got %h/%h/%b expected %h/%h/%b",
                             f, ln, rn, p.l, p.r, p.e, expL, expR, expE);
                end
                checks++;
                if (p.c != lsbCyc + 3) begin
                    errors++;
                    $display("[TB] FAIL random_latency[%0d]: got cycle %0d expected %0d", f, p.c, lsbCyc + 3);
                end
            end
            pulses.delete();
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_basic();
        test_mid_start();
        test_wide_slots();
        test_short_word();
        test_reset_mid_frame();
        test_random_frames();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

Serial-to-parallel I2S receiver: recovers stereo PCM samples from an external I2S bus (sck, ws, sd) that is asynchronous to the system clock. The block oversamples the bus lines, decodes Philips-format frames, and presents one left/right sample pair per frame with a single-cycle valid strobe. It sits at the audio input boundary, feeding the downstream sample-processing datapath in the `clk` domain.

## Interface
- `DATA_WIDTH`, 16, bits per channel sample delivered on the parallel outputs.
- `clk`  input  1  system clock. Must be ≥4× the sck frequency, with sck high and low phases each ≥2 clk periods.
- `reset`  input  1  synchronous, active-low reset (0 = reset), sampled on `clk` rising edge.
- `sck`  input  1  I2S serial clock, asynchronous to `clk`.
- `ws`  input  1  I2S word select: 0 = left, 1 = right.
- `sd`  input  1  I2S serial data, MSB first.
- `left_data`  output  DATA_WIDTH  last complete left sample.
- `right_data`  output  DATA_WIDTH  last complete right sample.
- `valid`  output  1  one-`clk` pulse when a new left/right pair is loaded.
- `word_err`  output  1  qualified by `valid`; 1 if either word in the pair had fewer than DATA_WIDTH bits.

## Operation
- `sck`, `ws`, `sd`: each passes through a 2-flop synchronizer. A registered copy of synchronized sck gives the rising-edge detect (sync = 1, delayed = 0). All bus sampling happens only on detected sck rising edges, using the synchronized ws/sd from the same stage.
- `ws_prev` holds ws from the previous sck rising edge. A transition is an sck rising edge where ws ≠ ws_prev.
- I2S framing:
  - ws changes one bit before the MSB.
  - The bit sampled on a transition edge is the LSB of the outgoing word.
  - The MSB of the new word is sampled on the next rising edge.
- State HUNT (after reset):
  - Track ws_prev and discard all data.
  - On a 1→0 transition, discard the sampled bit, clear `bit_cnt` and the shift word, and go to RUN.
- State RUN, on each sck rising edge:
  - If `bit_cnt` < DATA_WIDTH, write `sd` into word bit [DATA_WIDTH-1-bit_cnt].
  - `bit_cnt` increments, saturating at DATA_WIDTH.
  - Bits beyond DATA_WIDTH are dropped: MSB-justified truncation, not an error.
- On a RUN transition, the current edge's bit is included first, then the word is finalized.
  - 0→1 (left word complete): store the word in `left_hold`, plus short flag = (final count < DATA_WIDTH).
  - 1→0 (right word complete): `left_data` <= `left_hold`, `right_data` <= word, `valid` <= 1, `word_err` <= left short OR right short.
  - Either way, the word is then cleared to 0 and `bit_cnt` to 0.
- Short words leave the unwritten LSBs at 0.
- No backpressure: outputs hold until the next completed pair overwrites them.

## Timing
- Reset values: `left_data` = 0, `right_data` = 0, `valid` = 0, `word_err` = 0. Internal reset values: state = HUNT, ws_prev = 0, `bit_cnt` = 0, word = 0, `left_hold` = 0, synchronizer and edge flops = 0.
- Latency: if the sck rise carrying the right-word LSB (ws already 0) is first captured at `clk` edge N, the outputs update and `valid` = 1 after edge N+2, for exactly one cycle.
- `valid` never asserts twice per frame and never in HUNT. The first pulse after reset follows the first full left+right frame after the first 1→0 transition.
- `reset` asserted mid-frame: next `clk` edge forces all reset values and HUNT. A partial frame is never reported.
- Transition with `bit_cnt` = 0 (ws glitch or 1-bit slot): the word finalizes as 0, with short flag set.
- ws stuck (no transition): `bit_cnt` saturates, with no output and no error.

## Test plan
- Hold `reset` = 0 for 3 cycles with bus toggling → all outputs 0. Release, then drive sck at clk/8 with continuous frames → no `valid` before the first complete frame.
- 16-bit slots, left 0xA5C3, right 0x1234 → single `valid` pulse with `left_data` = 0xA5C3, `right_data` = 0x1234, `word_err` = 0. Confirm the N+2 latency from the right-LSB sck rise.
- Start the stream mid right word (ws = 1), then full frame left 0x0001, right 0x8000 → exactly one `valid`, carrying 0x0001/0x8000.
- 24-bit slots, left 0xABCDEF, right 0x123456 → `left_data` = 0xABCD, `right_data` = 0x1234, `word_err` = 0.
- 8-bit left slot 0xFF, 16-bit right 0x5555 → `left_data` = 0xFF00, `right_data` = 0x5555, `word_err` = 1.
- Assert `reset` midway through the right word of a frame → outputs 0 on the next edge. Release and send two frames → `valid` only for the second frame.
